// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: pipeline-facing control, forwarding and result bus of ex_muldiv_unit.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            Start_i;
  logic            Flush_i;
  logic [2:0]      Funct3_i;
  logic [XLEN-1:0] RS1Data_i;
  logic [XLEN-1:0] RS2Data_i;
  logic [XLEN-1:0] MEMFwd_i;
  logic [XLEN-1:0] WBFwd_i;
  logic [1:0]      ForwardA_i;
  logic [1:0]      ForwardB_i;
  logic            Busy_o;
  logic            Done_o;
  logic [XLEN-1:0] Result_o;

  modport master (
    output Start_i, Flush_i, Funct3_i, RS1Data_i, RS2Data_i,
           MEMFwd_i, WBFwd_i, ForwardA_i, ForwardB_i,
    input  Busy_o, Done_o, Result_o
  );

  modport slave (
    input  Start_i, Flush_i, Funct3_i, RS1Data_i, RS2Data_i,
           MEMFwd_i, WBFwd_i, ForwardA_i, ForwardB_i,
    output Busy_o, Done_o, Result_o
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide (32 shift-add / restoring-divide steps).
// Optional MULDIV_EARLY_OUT_EN: zero-operand ops jump straight from IDLE to DONE.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  ex_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [5:0] ITER_COUNT = 6'd32;

  function automatic logic signed_a_op(input logic [2:0] f3);
    case (f3)
      3'b001, 3'b010, 3'b100, 3'b110: signed_a_op = 1'b1;
      default:                        signed_a_op = 1'b0;
    endcase
  endfunction

  function automatic logic signed_b_op(input logic [2:0] f3);
    case (f3)
      3'b001, 3'b100, 3'b110: signed_b_op = 1'b1;
      default:                signed_b_op = 1'b0;
    endcase
  endfunction

  state_t              state_r, state_nxt_s;
  logic [5:0]          cnt_r;
  logic [2:0]          funct3_r;
  logic [XLEN-1:0]     op_a_r, op_b_r, mag_b_r, result_r;
  logic                neg_a_r, neg_b_r;
  logic [2*XLEN-1:0]   work_r, work_nxt_s, prod_s;
  logic [XLEN-1:0]     sel_a_s, sel_b_s, mag_a_s, mag_b_s, final_s, rem_s;
  logic                neg_a_s, neg_b_s, start_s, div_zero_s;
  logic [XLEN:0]       sum_s, shifted_s, diff_s;
`ifdef MULDIV_EARLY_OUT_EN
  logic                early_s;
  logic [XLEN-1:0]     early_res_s;
`endif

  assign start_s = (state_r == ST_IDLE) && bus.Start_i && !bus.Flush_i;

  // Forwarding muxes: pick each operand from RF, EX/MEM or MEM/WB.
  always_comb begin
    sel_a_s = bus.RS1Data_i;
    sel_b_s = bus.RS2Data_i;
    case (bus.ForwardA_i)
      2'b10:   sel_a_s = bus.MEMFwd_i;
      2'b01:   sel_a_s = bus.WBFwd_i;
      default: sel_a_s = bus.RS1Data_i;
    endcase
    case (bus.ForwardB_i)
      2'b10:   sel_b_s = bus.MEMFwd_i;
      2'b01:   sel_b_s = bus.WBFwd_i;
      default: sel_b_s = bus.RS2Data_i;
    endcase
  end

  // Sign/magnitude split of the selected operands; the core always runs unsigned.
  always_comb begin
    neg_a_s = signed_a_op(bus.Funct3_i) & sel_a_s[XLEN-1];
    neg_b_s = signed_b_op(bus.Funct3_i) & sel_b_s[XLEN-1];
    mag_a_s = neg_a_s ? -sel_a_s : sel_a_s;
    mag_b_s = neg_b_s ? -sel_b_s : sel_b_s;
  end

  // One iteration: work holds {acc_hi, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    sum_s     = {1'b0, work_r[2*XLEN-1:XLEN]} +
                (work_r[0] ? {1'b0, mag_b_r} : {(XLEN+1){1'b0}});
    shifted_s = work_r[2*XLEN-1:XLEN-1];
    diff_s    = shifted_s - {1'b0, mag_b_r};
    if (funct3_r[2]) begin
      if (!diff_s[XLEN]) begin
        work_nxt_s = {diff_s[XLEN-1:0], work_r[XLEN-2:0], 1'b1};
      end else begin
        work_nxt_s = {shifted_s[XLEN-1:0], work_r[XLEN-2:0], 1'b0};
      end
    end else begin
      work_nxt_s = {sum_s, work_r[XLEN-1:1]};
    end
  end

  // Sign fix-up and RV32M special cases applied to the last iteration's value.
  always_comb begin
    div_zero_s = (op_b_r == {XLEN{1'b0}});
    prod_s     = (neg_a_r ^ neg_b_r) ? -work_nxt_s : work_nxt_s;
    rem_s      = neg_a_r ? -work_nxt_s[2*XLEN-1:XLEN] : work_nxt_s[2*XLEN-1:XLEN];
    case (funct3_r)
      3'b000:                 final_s = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_s = prod_s[2*XLEN-1:XLEN];
      3'b100:  final_s = div_zero_s ? {XLEN{1'b1}} : prod_s[XLEN-1:0];
      3'b101:  final_s = div_zero_s ? {XLEN{1'b1}} : work_nxt_s[XLEN-1:0];
      3'b110:  final_s = div_zero_s ? op_a_r : rem_s;
      3'b111:  final_s = div_zero_s ? op_a_r : work_nxt_s[2*XLEN-1:XLEN];
      default: final_s = {XLEN{1'b0}};
    endcase
  end

`ifdef MULDIV_EARLY_OUT_EN
  // Zero-operand shortcut: result known at start without iterating.
  always_comb begin
    early_s = (sel_b_s == {XLEN{1'b0}}) ||
              ((sel_a_s == {XLEN{1'b0}}) && !bus.Funct3_i[2]);
    if (bus.Funct3_i[2] && (sel_b_s == {XLEN{1'b0}})) begin
      early_res_s = bus.Funct3_i[1] ? sel_a_s : {XLEN{1'b1}};
    end else begin
      early_res_s = {XLEN{1'b0}};
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; flush wins over everything once an op is in flight.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
`ifdef MULDIV_EARLY_OUT_EN
          state_nxt_s = early_s ? ST_DONE : ST_BUSY;
`else
          state_nxt_s = ST_BUSY;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (bus.Flush_i) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == 6'd1) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand capture at start (forwarded data is not stable while stalled) and iteration.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r    <= 6'd0;
      funct3_r <= 3'd0;
      op_a_r   <= {XLEN{1'b0}};
      op_b_r   <= {XLEN{1'b0}};
      mag_b_r  <= {XLEN{1'b0}};
      neg_a_r  <= 1'b0;
      neg_b_r  <= 1'b0;
      work_r   <= {(2*XLEN){1'b0}};
      result_r <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            cnt_r    <= ITER_COUNT;
            funct3_r <= bus.Funct3_i;
            op_a_r   <= sel_a_s;
            op_b_r   <= sel_b_s;
            mag_b_r  <= mag_b_s;
            neg_a_r  <= neg_a_s;
            neg_b_r  <= neg_b_s;
            work_r   <= {{XLEN{1'b0}}, mag_a_s};
`ifdef MULDIV_EARLY_OUT_EN
            if (early_s) begin
              result_r <= early_res_s;
            end
`endif
          end
        end
        ST_BUSY: begin
          if (!bus.Flush_i) begin
            work_r <= work_nxt_s;
            cnt_r  <= cnt_r - 6'd1;
            if (cnt_r == 6'd1) begin
              result_r <= final_s;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.Busy_o   = start_s || (state_r == ST_BUSY);
  assign bus.Done_o   = (state_r == ST_DONE);
  assign bus.Result_o = result_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: randomized scoreboard bench for ex_muldiv_unit against an arithmetic model.
module tb_ex_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] last_res = 32'd0;

  typedef struct {
    logic [31:0] res;
    int          start;
    int          lat;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  ex_muldiv_unit_if #(.XLEN(32)) bus_if ();
  ex_muldiv_unit #(.XLEN(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus_if));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // RV32M reference semantics with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] fwd_sel(input logic [1:0] f, input logic [31:0] rf,
                                          input logic [31:0] mem, input logic [31:0] wb);
    if (f == 2'b10) return mem;
    if (f == 2'b01) return wb;
    return rf;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every Done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus_if.Done_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: Done_o=1 with no op outstanding (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, " result"}, bus_if.Result_o, mon_e.res);
        check({mon_e.name, " latency"}, cyc - mon_e.start, mon_e.lat);
        check({mon_e.name, " busy_in_done"}, {31'd0, bus_if.Busy_o}, 32'd0);
      end
    end
  end

  task automatic set_idle();
    bus_if.Start_i = 1'b0;   bus_if.Flush_i = 1'b0;   bus_if.Funct3_i = 3'd0;
    bus_if.RS1Data_i = 32'd0; bus_if.RS2Data_i = 32'd0;
    bus_if.MEMFwd_i = 32'd0;  bus_if.WBFwd_i = 32'd0;
    bus_if.ForwardA_i = 2'b00; bus_if.ForwardB_i = 2'b00;
  endtask

  task automatic scramble();
    bus_if.RS1Data_i = $urandom; bus_if.RS2Data_i = $urandom;
    bus_if.MEMFwd_i = $urandom;  bus_if.WBFwd_i = $urandom;
    bus_if.ForwardA_i = 2'($urandom); bus_if.ForwardB_i = 2'($urandom);
    bus_if.Funct3_i = 3'($urandom);
  endtask

  task automatic drive_op(input logic [2:0] f3, input logic [1:0] fa, input logic [1:0] fb,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] mem, input logic [31:0] wb);
    bus_if.Funct3_i = f3; bus_if.ForwardA_i = fa; bus_if.ForwardB_i = fb;
    bus_if.RS1Data_i = rs1; bus_if.RS2Data_i = rs2;
    bus_if.MEMFwd_i = mem;  bus_if.WBFwd_i = wb;
    bus_if.Start_i = 1'b1;  bus_if.Flush_i = 1'b0;
  endtask

  // Issue one op in IDLE, push the expectation, and let the monitor retire it.
  task automatic issue_op(input string name, input logic [2:0] f3, input logic [1:0] fa,
                          input logic [1:0] fb, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] mem, input logic [31:0] wb);
    logic [31:0] a, b;
    logic        busy_ok;
    exp_t        e;
    drive_op(f3, fa, fb, rs1, rs2, mem, wb);
    a = fwd_sel(fa, rs1, mem, wb);
    b = fwd_sel(fb, rs2, mem, wb);
    e.res   = ref_model(f3, a, b);
    e.start = cyc;
    e.name  = name;
`ifdef MULDIV_EARLY_OUT_EN
    e.lat = (b == 32'd0 || (a == 32'd0 && !f3[2])) ? 1 : 33;
`else
    e.lat = 33;
`endif
    exp_q.push_back(e);
    #1;
    check({name, " busy_c0"}, {31'd0, bus_if.Busy_o}, 32'd1);
    busy_ok = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(negedge clk); #1;
      bus_if.Start_i = 1'b0;
      if (exp_q.size() != 0 && bus_if.Busy_o !== 1'b1) busy_ok = 1'b0;
      scramble();
    end
    check({name, " busy_hold"}, {31'd0, busy_ok}, 32'd1);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no Done_o within 60 cycles", name);
      exp_q.delete();
    end
    @(negedge clk); #1;
    check({name, " result_hold"}, bus_if.Result_o, e.res);
    last_res = e.res;
  endtask

  initial begin
    set_idle();
    repeat (3) @(negedge clk);
    #1;
    check("reset busy", {31'd0, bus_if.Busy_o}, 32'd0);
    check("reset done", {31'd0, bus_if.Done_o}, 32'd0);
    check("reset result", bus_if.Result_o, 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    // Start together with Flush in IDLE must not launch anything.
    drive_op(3'd0, 2'b00, 2'b00, 32'd3, 32'd4, 32'd0, 32'd0);
    bus_if.Flush_i = 1'b1;
    #1;
    check("start_flush busy", {31'd0, bus_if.Busy_o}, 32'd0);
    @(negedge clk); #1;
    set_idle();
    check("start_flush idle", {31'd0, bus_if.Busy_o}, 32'd0);
    repeat (36) @(negedge clk);
    #1;

    issue_op("mul_fwd",      3'd0, 2'b10, 2'b00, $urandom, 32'd6, 32'd7, $urandom);
    issue_op("mulh_m1",      3'd1, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
    issue_op("mulhu_m1",     3'd3, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
    issue_op("mulhsu_m1x2",  3'd2, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
    issue_op("div_m7_2",     3'd4, 2'b01, 2'b11, 32'd0, 32'd2, 32'd0, 32'hFFFF_FFF9);
    issue_op("rem_m7_2",     3'd6, 2'b01, 2'b10, 32'd0, 32'd0, 32'd2, 32'hFFFF_FFF9);
    issue_op("divu_min_m1",  3'd5, 2'b00, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
    issue_op("div_by0",      3'd4, 2'b00, 2'b00, 32'hFFFF_FFFB, 32'd0, 32'd0, 32'd0);
    issue_op("rem_by0",      3'd6, 2'b00, 2'b00, 32'hFFFF_FFFB, 32'd0, 32'd0, 32'd0);
    issue_op("remu_by0",     3'd7, 2'b10, 2'b01, 32'd0, 32'd0, 32'h1234_5678, 32'd0);
    issue_op("div_ovf",      3'd4, 2'b00, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
    issue_op("rem_ovf",      3'd6, 2'b00, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
    issue_op("mul_a0",       3'd0, 2'b00, 2'b00, 32'd0, 32'd99, 32'd0, 32'd0);

    for (int n = 0; n < 40; n++) begin
      issue_op("rand", 3'($urandom), 2'($urandom), 2'($urandom),
               pick_val(), pick_val(), pick_val(), pick_val());
    end

    issue_op("mul_fwd_again", 3'd0, 2'b10, 2'b00, $urandom, 32'd6, 32'd7, $urandom);

    // Flush at cycle 10 of an op: back to IDLE at cycle 11, no Done_o, result untouched.
    drive_op(3'd4, 2'b00, 2'b00, 32'd1000, 32'd7, 32'd0, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); #1;
      bus_if.Start_i = 1'b0;
    end
    bus_if.Flush_i = 1'b1;
    @(negedge clk); #1;
    bus_if.Flush_i = 1'b0;
    check("flush busy", {31'd0, bus_if.Busy_o}, 32'd0);
    check("flush done", {31'd0, bus_if.Done_o}, 32'd0);
    repeat (40) @(negedge clk);
    #1;
    check("flush result_kept", bus_if.Result_o, last_res);

    // Reset at cycle 5 of an op clears everything and suppresses Done_o.
    drive_op(3'd1, 2'b00, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0);
    @(negedge clk); #1;
    bus_if.Start_i = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk); #1;
    check("midop_reset busy", {31'd0, bus_if.Busy_o}, 32'd0);
    check("midop_reset done", {31'd0, bus_if.Done_o}, 32'd0);
    check("midop_reset result", bus_if.Result_o, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    #1;

    issue_op("mul_after_reset", 3'd0, 2'b00, 2'b00, 32'd3, 32'd5, 32'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
